// File: rtl/mont_mul_radix2.sv
// mont_mul_radix2: bit-serial radix-2 Montgomery multiplier, R = A*B*2^-K mod M.
// One multiplier bit per clock, followed by a single correction subtract.
// Optional build macro MONT_INPUT_CHECK_EN adds operand checking and the err output.

module cla_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic         gacc;
  logic         pacc;
  logic         cgrp;
  logic         ccur;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups; each carry inside a group is formed from the group's incoming carry
  always_comb begin
    sum  = '0;
    ccur = cin;
    cgrp = cin;
    gacc = 1'b0;
    pacc = 1'b1;
    for (int k = 0; k < W; k++) begin
      if (k % 4 == 0) begin
        cgrp = ccur;
        gacc = 1'b0;
        pacc = 1'b1;
      end
      sum[k] = p[k] ^ ccur;
      gacc   = g[k] | (p[k] & gacc);
      pacc   = pacc & p[k];
      ccur   = gacc | (pacc & cgrp);
    end
    cout = ccur;
  end
endmodule

module mont_mul_radix2 #(
  parameter int K = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [K-1:0] a_in,
  input  logic [K-1:0] b_in,
  input  logic [K-1:0] m_in,
  output logic         busy,
  output logic         done,
`ifdef MONT_INPUT_CHECK_EN
  output logic         err,
`endif
  output logic [K-1:0] result
);
  localparam int IW = $clog2(K);

  typedef enum logic [1:0] {IDLE, LOOP, CORR, DONE} state_t;

  state_t          state;
  logic [K-1:0]    a_q;
  logic [K-1:0]    b_q;
  logic [K-1:0]    m_q;
  logic [K+1:0]    s_q;
  logic [IW-1:0]   i_q;

  logic            q_bit;
  logic [K+1:0]    add1_b;
  logic [K+1:0]    t1;
  logic            t1_c;
  logic [K+1:0]    add2_b;
  logic [K+1:0]    t2_low;
  logic            t2_c;
  logic [K+2:0]    t2;
  logic [K+1:0]    d_sum;
  logic            d_c;
  logic            unused_bits;

  assign q_bit  = s_q[0] ^ (a_q[i_q] & b_q[0]);
  assign add1_b = a_q[i_q] ? {2'b00, b_q} : '0;
  assign add2_b = q_bit ? {2'b00, m_q} : '0;
  assign t2     = {t2_c, t2_low};

  // T1 = S + A[i]*B
  cla_adder #(.W(K+2)) u_add1 (.a(s_q), .b(add1_b), .cin(1'b0), .sum(t1), .cout(t1_c));
  // T2 = T1 + q*M; the carry-out is kept so the halving never loses a bit
  cla_adder #(.W(K+2)) u_add2 (.a(t1), .b(add2_b), .cin(1'b0), .sum(t2_low), .cout(t2_c));
  // D = S - M; carry-out high means S >= M
  cla_adder #(.W(K+2)) u_sub (.a(s_q), .b(~{2'b00, m_q}), .cin(1'b1), .sum(d_sum), .cout(d_c));

  // T1 cannot overflow under S < 2M, T2 is always even, and D's top bits are discarded
  assign unused_bits = ^{t1_c, t2_low[0], d_sum[K+1:K]};

`ifdef MONT_INPUT_CHECK_EN
  logic bad_ops;
  assign bad_ops = ~m_in[0] | (a_in >= m_in) | (b_in >= m_in);
`endif

  // Controller and datapath registers: capture, iterate, correct, report
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      s_q    <= '0;
      i_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
`ifdef MONT_INPUT_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a_in;
            b_q <= b_in;
            m_q <= m_in;
            s_q <= '0;
            i_q <= '0;
`ifdef MONT_INPUT_CHECK_EN
            err <= bad_ops;
            if (bad_ops) begin
              result <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= LOOP;
            end
`else
            busy  <= 1'b1;
            state <= LOOP;
`endif
          end
        end
        LOOP: begin
          s_q <= t2[K+2:1];
          if (i_q == IW'(K-1)) state <= CORR;
          else i_q <= i_q + IW'(1);
        end
        CORR: begin
          result <= d_c ? d_sum[K-1:0] : s_q[K-1:0];
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
